// File: rtl/ring_sequencer.sv
// Multi-mode ring sequencer: one-hot rotate, Johnson counter and one-hot ping-pong,
// with synchronous load, a registered wrap pulse and a sticky invalid-state flag.
module ring_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_PING    = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    typedef enum logic {
        PDIR_UP   = 1'b0,
        PDIR_DOWN = 1'b1
    } pdir_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_err;
    pdir_e            r_pdir;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_err_nxt;
    pdir_e            w_pdir_nxt;

    logic             w_zero;
    logic             w_onehot_ok;
    logic             w_john_ok;
    logic [WIDTH-1:0] w_q_inv;
    logic [WIDTH-1:0] w_rot_l;
    logic [WIDTH-1:0] w_rot_r;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_john;

    // Validity: one-hot allows zero; Johnson states are low-ones runs or their complements.
    assign w_zero      = (r_q == '0);
    assign w_onehot_ok = ((r_q & (r_q - ONE)) == '0);
    assign w_q_inv     = ~r_q;
    assign w_john_ok   = ((r_q & (r_q + ONE)) == '0) || ((w_q_inv & (w_q_inv + ONE)) == '0);

    assign w_rot_l = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_rot_r = {r_q[0], r_q[WIDTH-1:1]};
    assign w_shl   = r_q << 1;
    assign w_shr   = r_q >> 1;
    assign w_john  = dir ? {~r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};

    // Next-state selection: load beats advance; idle holds state and drops wrap.
    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        w_err_nxt  = r_err;
        w_pdir_nxt = r_pdir;
        if (load) begin
            w_q_nxt    = load_val;
            w_pdir_nxt = PDIR_UP;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_RING: begin
                    if (w_zero) begin
                        w_q_nxt = dir ? MSB : ONE;
                    end else if (w_onehot_ok) begin
                        w_q_nxt    = dir ? w_rot_r : w_rot_l;
                        w_wrap_nxt = dir ? r_q[0] : r_q[WIDTH-1];
                    end else begin
                        w_q_nxt   = ONE;
                        w_err_nxt = 1'b1;
                    end
                end
                MODE_JOHNSON: begin
                    if (w_john_ok) begin
                        w_q_nxt    = w_john;
                        w_wrap_nxt = (w_john == '0);
                    end else begin
                        w_q_nxt   = '0;
                        w_err_nxt = 1'b1;
                    end
                end
                MODE_PING: begin
                    if (w_zero) begin
                        w_q_nxt    = ONE;
                        w_pdir_nxt = PDIR_UP;
                    end else if (w_onehot_ok) begin
                        if (r_pdir == PDIR_UP) begin
                            if (r_q[WIDTH-1]) begin
                                w_q_nxt    = w_shr;
                                w_pdir_nxt = PDIR_DOWN;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_q_nxt = w_shl;
                            end
                        end else begin
                            if (r_q[0]) begin
                                w_q_nxt    = w_shl;
                                w_pdir_nxt = PDIR_UP;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_q_nxt = w_shr;
                            end
                        end
                    end else begin
                        w_q_nxt    = ONE;
                        w_pdir_nxt = PDIR_UP;
                        w_err_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_q_nxt = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            r_pdir <= PDIR_UP;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
            r_err  <= w_err_nxt;
            r_pdir <= w_pdir_nxt;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule
